// File: rtl/issue_regread_stage_pkg.sv
// Shared types for the issue/register-read stage: micro-op base info, FU option
// code, execute-side payload and the writeback bypass selector.
package issue_regread_stage_pkg;

  localparam int unsigned PHY_REG_NUM = 64;
  localparam int unsigned WB_WIDTH    = 4;
  localparam int unsigned PREG_W      = $clog2(PHY_REG_NUM);
  localparam int unsigned WB_IDX_W    = $clog2(WB_WIDTH);
  localparam int unsigned ROB_W       = 5;
  localparam int unsigned XLEN        = 32;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t            psrc0;
    preg_t            psrc1;
    logic             psrc0_valid;
    logic             psrc1_valid;
    preg_t            pdest;
    logic [ROB_W-1:0] rob_idx;
    logic             position_bit;
  } IssueBaseSt;

  typedef struct packed {
    logic [3:0] fu_op;
    logic [1:0] sub_op;
  } OptionCodeSt;

  typedef struct packed {
    IssueBaseSt      base;
    logic [XLEN-1:0] src0;
    logic [XLEN-1:0] src1;
  } ExeBaseSt;

  typedef struct packed {
    logic                hit;
    logic [WB_IDX_W-1:0] idx;
  } BypassSelSt;

  // Lowest-index writeback port whose tag matches src wins.
  function automatic BypassSelSt bypass_sel(
    input logic  [WB_WIDTH-1:0] wb_valid,
    input preg_t [WB_WIDTH-1:0] wb_tag,
    input preg_t                src
  );
    BypassSelSt sel;
    sel = '0;
    for (int unsigned k = 0; k < WB_WIDTH; k++) begin
      if (!sel.hit && wb_valid[k] && (wb_tag[k] == src)) begin
        sel.hit = 1'b1;
        sel.idx = WB_IDX_W'(k);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/issue_regread_stage_lane.sv
// One lane: S1 register-read slot with writeback bypass, feeding a 2-entry FIFO
// toward the functional unit.
module regread_lane
  import issue_regread_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter type         OPTION_CODE = OptionCodeSt
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  input  IssueBaseSt                         issue_base_i,
  input  OPTION_CODE                         issue_oc_i,
  output logic                               issue_ready_o,
  output logic [1:0][PREG_W-1:0]             rf_raddr_o,
  input  logic [1:0][DATA_WIDTH-1:0]         rf_rdata_i,
  input  logic [WB_WIDTH-1:0]                wb_pdest_valid_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]    wb_pdest_i,
  input  logic [WB_WIDTH-1:0][DATA_WIDTH-1:0] wb_data_i,
  output logic                               exe_valid_o,
  input  logic                               exe_ready_i,
  output IssueBaseSt                         exe_base_o,
  output OPTION_CODE                         exe_oc_o,
  output logic [DATA_WIDTH-1:0]              exe_src0_o,
  output logic [DATA_WIDTH-1:0]              exe_src1_o
);

  logic                        s1_valid_q;
  IssueBaseSt                  s1_base_q;
  OPTION_CODE                  s1_oc_q;
  logic [1:0]                  s1_hit_q;
  logic [1:0][DATA_WIDTH-1:0]  s1_hit_data_q;
  logic                        s1_resolved_q;
  logic [1:0][DATA_WIDTH-1:0]  s1_opnd_q;

  IssueBaseSt                  fifo_base_q [2];
  OPTION_CODE                  fifo_oc_q   [2];
  logic [DATA_WIDTH-1:0]       fifo_src0_q [2];
  logic [DATA_WIDTH-1:0]       fifo_src1_q [2];
  logic                        wr_ptr_q;
  logic                        rd_ptr_q;
  logic [1:0]                  cnt_q;

  logic                        accept;
  logic                        deq;
  logic                        enq;
  logic [1:0]                  cnt_after_deq;
  logic [1:0][PREG_W-1:0]      acc_src;
  logic [1:0][PREG_W-1:0]      s1_src;
  logic [1:0]                  s1_src_valid;
  BypassSelSt [1:0]            acc_sel;
  BypassSelSt [1:0]            s1_sel;
  logic [1:0][DATA_WIDTH-1:0]  opnd;

  assign issue_ready_o = ~(s1_valid_q & (cnt_q == 2'd2));
  assign accept        = issue_valid_i & issue_ready_o;
  assign exe_valid_o   = (cnt_q != 2'd0);
  assign deq           = exe_valid_o & exe_ready_i;
  assign cnt_after_deq = cnt_q - {1'b0, deq};
  assign enq           = s1_valid_q & (cnt_after_deq != 2'd2);

  assign rf_raddr_o[0] = issue_base_i.psrc0;
  assign rf_raddr_o[1] = issue_base_i.psrc1;

  assign exe_base_o = fifo_base_q[rd_ptr_q];
  assign exe_oc_o   = fifo_oc_q[rd_ptr_q];
  assign exe_src0_o = fifo_src0_q[rd_ptr_q];
  assign exe_src1_o = fifo_src1_q[rd_ptr_q];

  // Priority: S1-cycle writeback, then accept-cycle capture, then RF data.
  // Once resolved, the held op keeps its captured operands (RF port has moved on).
  always_comb begin
    acc_src[0]      = issue_base_i.psrc0;
    acc_src[1]      = issue_base_i.psrc1;
    s1_src[0]       = s1_base_q.psrc0;
    s1_src[1]       = s1_base_q.psrc1;
    s1_src_valid[0] = s1_base_q.psrc0_valid;
    s1_src_valid[1] = s1_base_q.psrc1_valid;
    for (int unsigned n = 0; n < 2; n++) begin
      acc_sel[n] = bypass_sel(wb_pdest_valid_i, wb_pdest_i, acc_src[n]);
      s1_sel[n]  = bypass_sel(wb_pdest_valid_i, wb_pdest_i, s1_src[n]);
      opnd[n]    = '0;
      if (s1_src_valid[n]) begin
        if (s1_resolved_q)       opnd[n] = s1_opnd_q[n];
        else if (s1_sel[n].hit)  opnd[n] = wb_data_i[s1_sel[n].idx];
        else if (s1_hit_q[n])    opnd[n] = s1_hit_data_q[n];
        else                     opnd[n] = rf_rdata_i[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s1_valid_q    <= 1'b0;
      s1_resolved_q <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (accept) begin
        s1_valid_q    <= 1'b1;
        s1_resolved_q <= 1'b0;
        s1_base_q     <= issue_base_i;
        s1_oc_q       <= issue_oc_i;
        for (int unsigned n = 0; n < 2; n++) begin
          s1_hit_q[n]      <= acc_sel[n].hit;
          s1_hit_data_q[n] <= wb_data_i[acc_sel[n].idx];
        end
      end else if (enq) begin
        s1_valid_q <= 1'b0;
      end else if (s1_valid_q) begin
        s1_resolved_q <= 1'b1;
        s1_opnd_q     <= opnd;
      end
      if (enq) begin
        fifo_base_q[wr_ptr_q] <= s1_base_q;
        fifo_oc_q[wr_ptr_q]   <= s1_oc_q;
        fifo_src0_q[wr_ptr_q] <= opnd[0];
        fifo_src1_q[wr_ptr_q] <= opnd[1];
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_after_deq + {1'b0, enq};
    end
  end

endmodule

// File: rtl/issue_regread_stage.sv
// Issue/register-read stage between the reservation station and the FUs;
// LANE_NUM independent regread_lane copies sharing the writeback bus.
module issue_regread_stage
  import issue_regread_stage_pkg::*;
#(
  parameter int unsigned LANE_NUM    = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter type         OPTION_CODE = OptionCodeSt
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush_i,
  input  logic [LANE_NUM-1:0]                     issue_valid_i,
  input  IssueBaseSt [LANE_NUM-1:0]               issue_base_i,
  input  OPTION_CODE [LANE_NUM-1:0]               issue_oc_i,
  output logic [LANE_NUM-1:0]                     issue_ready_o,
  output logic [LANE_NUM-1:0][1:0][PREG_W-1:0]    rf_raddr_o,
  input  logic [LANE_NUM-1:0][1:0][DATA_WIDTH-1:0] rf_rdata_i,
  input  logic [WB_WIDTH-1:0]                     wb_pdest_valid_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]         wb_pdest_i,
  input  logic [WB_WIDTH-1:0][DATA_WIDTH-1:0]     wb_data_i,
  output logic [LANE_NUM-1:0]                     exe_valid_o,
  input  logic [LANE_NUM-1:0]                     exe_ready_i,
  output IssueBaseSt [LANE_NUM-1:0]               exe_base_o,
  output OPTION_CODE [LANE_NUM-1:0]               exe_oc_o,
  output logic [LANE_NUM-1:0][DATA_WIDTH-1:0]     exe_src0_o,
  output logic [LANE_NUM-1:0][DATA_WIDTH-1:0]     exe_src1_o
);

  for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
    regread_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .OPTION_CODE (OPTION_CODE)
    ) u_lane (
      .clk              (clk),
      .rst              (rst),
      .flush_i          (flush_i),
      .issue_valid_i    (issue_valid_i[l]),
      .issue_base_i     (issue_base_i[l]),
      .issue_oc_i       (issue_oc_i[l]),
      .issue_ready_o    (issue_ready_o[l]),
      .rf_raddr_o       (rf_raddr_o[l]),
      .rf_rdata_i       (rf_rdata_i[l]),
      .wb_pdest_valid_i (wb_pdest_valid_i),
      .wb_pdest_i       (wb_pdest_i),
      .wb_data_i        (wb_data_i),
      .exe_valid_o      (exe_valid_o[l]),
      .exe_ready_i      (exe_ready_i[l]),
      .exe_base_o       (exe_base_o[l]),
      .exe_oc_o         (exe_oc_o[l]),
      .exe_src0_o       (exe_src0_o[l]),
      .exe_src1_o       (exe_src1_o[l])
    );
  end

endmodule

// File: doc/issue_regread_stage.md
Name: issue_regread_stage

Overview:
- Sits directly downstream of the reservation station, between its issue port and the functional units.
- Per lane:
  - accepts one issued micro-op per cycle;
  - reads source operands from the synchronous physical register file;
  - bypasses writeback results;
  - buffers ready-to-execute ops in a 2-entry FIFO toward the FU with valid/ready handshake.
- Flush discards all in-flight state.

Parameters:
- LANE_NUM, 2, number of independent lanes (matches RS BANK_NUM).
- DATA_WIDTH, 32, operand width.
- OPTION_CODE, OptionCodeSt, FU option-code type passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous pipeline flush.
- issue_valid_i  in  LANE_NUM  op valid from RS.
- issue_base_i  in  LANE_NUM x IssueBaseSt  psrc0/1, psrc0/1_valid, pdest, rob_idx, position_bit.
- issue_oc_i  in  LANE_NUM x OPTION_CODE  option code.
- issue_ready_o  out  LANE_NUM  stage can accept.
- rf_raddr_o  out  LANE_NUM x 2 x $clog2(`PHY_REG_NUM)  RF read addresses; data returns next cycle.
- rf_rdata_i  in  LANE_NUM x 2 x DATA_WIDTH  RF read data (read-during-write returns old value).
- wb_pdest_valid_i  in  `WB_WIDTH  writeback valid.
- wb_pdest_i  in  `WB_WIDTH x $clog2(`PHY_REG_NUM)  writeback tag.
- wb_data_i  in  `WB_WIDTH x DATA_WIDTH  writeback value.
- exe_valid_o  out  LANE_NUM  op valid to FU.
- exe_ready_i  in  LANE_NUM  FU accepts.
- exe_base_o  out  LANE_NUM x IssueBaseSt  op info.
- exe_oc_o  out  LANE_NUM x OPTION_CODE  option code.
- exe_src0_o, exe_src1_o  out  LANE_NUM x DATA_WIDTH  operands (0 when psrcN_valid=0).

Behaviour:
- Reset: rst (sync, active-high) clears S1 valid, FIFO pointers and counts. Next cycle exe_valid_o=0 and issue_ready_o=1. Payload outputs are don't-care.
- flush_i behaves identically to rst. It has priority over any simultaneous accept or dequeue.
- Stage S1, per lane:
  - An accept (issue_valid_i & issue_ready_o) registers base and oc into S1.
  - rf_raddr_o is driven combinationally from issue_base_i.psrcN in the same cycle.
- Bypass, accept cycle:
  - For each wb port k with valid and wb_pdest_i[k]==psrcN, latch hitN=1 and hit_dataN=wb_data_i[k].
  - If several ports match, the lowest k wins.
- Bypass, S1 cycle:
  - operandN is wb_data of a current-cycle match on S1.psrcN (lowest k) if one exists;
  - else hit_dataN if hitN;
  - else rf_rdata_i.
  - psrcN_valid=0 forces operandN=0.
- S1 to FIFO: S1 moves into the FIFO when FIFO count after this cycle's dequeue is <2. Otherwise S1 holds, with operands already resolved.
- Holding S1 (captured-operands variant, the only permitted implementation):
  - On the first S1 cycle, resolved operands are captured into S1 operand registers and a resolved flag is set.
  - Later cycles use the registers.
  - The RF is not re-read.
- FIFO: 2 entries, circular pointers. Output is combinational from the head entry. exe_valid_o = count!=0.
- Dequeue happens on exe_valid_o & exe_ready_i. Enqueue and dequeue in the same cycle keep count unchanged.
- issue_ready_o = ~(S1_valid & count==2), computed from registered state only. Per-lane capacity is 3 ops.
- Back-to-back: with exe_ready_i held at 1, one op per cycle sustains. Latency from accept to exe_valid_o is 2 cycles.
- Lanes are fully independent. There is no ordering between lanes.

Decomposition:
- Package (Scheduler.svh): the ExeBaseSt typedef (IssueBaseSt plus two DATA_WIDTH operands) and the bypass-select function (lowest-index match over `WB_WIDTH).
- One natural sub-module: regread_lane, which instantiates S1, the bypass and the FIFO for one lane. The top generates LANE_NUM copies.

Test Plan:
- Reset then idle: assert rst 1 cycle -> exe_valid_o=0, issue_ready_o=2'b11 next cycle.
- Single op, psrc0=5, psrc1=9, RF p5=0x11, p9=0x22, exe_ready=1 -> exe_valid at accept+2, src0=0x11, src1=0x22.
- Bypass:
  - accept-cycle wb p5=0xAA -> src0=0xAA, not the old RF value;
  - S1-cycle wb p9=0xBB -> src1=0xBB;
  - two wb ports tagging p5 with 0x1/0x2 -> 0x1.
- Backpressure: exe_ready=0, issue 4 ops in a stream -> 3 accepted, then issue_ready_o=0; release exe_ready -> in-order drain, operands intact, no RF re-read effect.
- Full-rate stream: 8 ops, exe_ready=1 constant -> 8 consecutive exe_valid cycles, issue_ready_o never drops.
- Flush with S1 and FIFO both occupied, concurrent accept -> next cycle exe_valid_o=0, no flushed op ever appears.
